// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore state decode, retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes halt the FSM instead of retiring as NOPs.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             iord,
  output logic             alu_src_a,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur, nxt;
  logic   pcw_raw, irw_raw, mw_raw, rw_raw;

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      nxt = HALT;
`else
          default:      nxt = FETCH;
`endif
        endcase
      end
      MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      HALT:   nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // Any entry into FETCH from another state retires exactly one instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= FETCH;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (nxt == FETCH && cur != FETCH)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    pcw_raw    = 1'b0;
    irw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (cur)
      FETCH: begin
        alu_src_b = 2'b01;
        irw_raw   = mem_ready;
        pcw_raw   = mem_ready;
      end
      DECODE:  alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        rw_raw     = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        mw_raw = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst = 1'b1;
        rw_raw  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
      end
      ADDIWB:  rw_raw = 1'b1;
      JUMP: begin
        pc_src  = 2'b10;
        pcw_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so FETCH's mem_ready dependence cannot leak through.
  assign pc_write  = reset & pcw_raw;
  assign ir_write  = reset & irw_raw;
  assign mem_write = reset & mw_raw;
  assign reg_write = reset & rw_raw;
  assign pc_en     = reset & (pcw_raw | ((cur == BRANCH) & zero));
  assign state     = cur;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (cur == HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule
